magphase_gain_fork: RTL

- Parametrised polar-domain gain stage that sits after a cartesian-to-polar CORDIC in a magnitude/phase RFNoC block.
- Takes one AXI-stream of {magnitude, phase} words.
- Applies a slew-limited programmable gain to the magnitude, then rounds and clips it.
- Forks the result into independent magnitude and phase output streams, each with its own tready.

---
 rtl/magphase_gain_fork_pkg.sv | 19 +
 rtl/magphase_gain_fork_if.sv | 29 ++
 rtl/magphase_gain_fork_axis_fork2.sv | 64 ++++++
 rtl/magphase_gain_fork.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/magphase_gain_fork_pkg.sv
// Shared constants and types for the magnitude/phase gain stage.
package magphase_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // Largest non-negative magnitude representable in a signed field of 'width' bits.
    function automatic logic [31:0] MAG_MAX(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Half an LSB of the integer result, added before the fractional bits are dropped.
    function automatic logic [31:0] ROUND_OFS(input int unsigned frac);
        return 32'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/magphase_gain_fork_if.sv
// Stream bundle for magphase_gain_fork: one {mag,phase} input, separate magnitude and phase outputs.
interface magphase_gain_fork_if #(
    parameter int WIDTH = 16
);
    logic [2*WIDTH-1:0] i_tdata;
    logic               i_tlast;
    logic               i_tvalid;
    logic               i_tready;

    logic [WIDTH-1:0]   om_tdata;
    logic               om_tlast;
    logic               om_tvalid;
    logic               om_tready;

    logic [WIDTH-1:0]   op_tdata;
    logic               op_tlast;
    logic               op_tvalid;
    logic               op_tready;

    modport slave (
        input  i_tdata, i_tlast, i_tvalid, om_tready, op_tready,
        output i_tready, om_tdata, om_tlast, om_tvalid, op_tdata, op_tlast, op_tvalid
    );

    modport master (
        output i_tdata, i_tlast, i_tvalid, om_tready, op_tready,
        input  i_tready, om_tdata, om_tlast, om_tvalid, op_tdata, op_tlast, op_tvalid
    );
endinterface

// File: rtl/magphase_gain_fork_axis_fork2.sv
// axis_fork2: one-word register feeding two independent consumers; retires once both have taken it.
module axis_fork2 #(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [A_W-1:0] i_a_data,
    input  logic [B_W-1:0] i_b_data,
    output logic [A_W-1:0] o_a_data,
    output logic           o_a_valid,
    input  logic           i_a_ready,
    output logic [B_W-1:0] o_b_data,
    output logic           o_b_valid,
    input  logic           i_b_ready
);
    logic           r_valid;
    logic           r_a_done;
    logic           r_b_done;
    logic [A_W-1:0] r_a_data;
    logic [B_W-1:0] r_b_data;
    logic           w_a_hs;
    logic           w_b_hs;
    logic           w_retire;
    logic           w_load;

    assign o_a_valid = r_valid & ~r_a_done;
    assign o_b_valid = r_valid & ~r_b_done;
    assign o_a_data  = r_a_data;
    assign o_b_data  = r_b_data;
    assign w_a_hs    = o_a_valid & i_a_ready;
    assign w_b_hs    = o_b_valid & i_b_ready;
    // A word retires when each branch has either already taken it or takes it now.
    assign w_retire  = r_valid & (r_a_done | w_a_hs) & (r_b_done | w_b_hs);
    assign o_ready   = ~r_valid | w_retire;
    assign w_load    = i_valid & o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_a_data <= '0;
            r_b_data <= '0;
        end else begin
            if (w_load) begin
                r_valid  <= 1'b1;
                r_a_data <= i_a_data;
                r_b_data <= i_b_data;
            end else if (w_retire) begin
                r_valid <= 1'b0;
            end
            if (w_load || w_retire) begin
                r_a_done <= 1'b0;
                r_b_done <= 1'b0;
            end else begin
                if (w_a_hs) r_a_done <= 1'b1;
                if (w_b_hs) r_b_done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/magphase_gain_fork.sv
// magphase_gain_fork: slew-limited gain on magnitude (multiply, round/clip), then fork to mag/phase streams.
// Optional saturation counter is built when MAGPHASE_GAIN_SAT_CNT_EN is defined.
import magphase_pkg::*;

module magphase_gain_fork #(
    parameter int WIDTH      = 16,
    parameter int GAIN_W     = 16,
    parameter int GAIN_FRAC  = 12,
    parameter int STEP_W     = 8,
    parameter int GAIN_RESET = 4096
) (
    input  logic                ce_clk,
    input  logic                ce_rst_n,
    magphase_gain_fork_if.slave bus,
    input  logic [GAIN_W-1:0]   set_gain,
    input  logic                set_gain_stb,
    input  logic [STEP_W-1:0]   ramp_step,
    output logic                ramping,
    input  logic                sat_clear,
    output logic [15:0]         sat_count
);
    localparam int PROD_W = WIDTH + GAIN_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int RND_W  = SUM_W - GAIN_FRAC;
    localparam logic [SUM_W-1:0]  RND_OFS  = SUM_W'(ROUND_OFS(GAIN_FRAC));
    localparam logic [WIDTH-1:0]  MAG_LIM  = WIDTH'(MAG_MAX(WIDTH));
    localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_RESET);

    // Valid/ready: a word moves on a clock edge where valid and ready are both high; valid never
    // depends on ready, and a stage is ready when it is empty or its content leaves this cycle.
    logic              w_f_ready;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_hs;
    logic              w_s2_load;

    logic              r_s1_valid;
    logic [PROD_W-1:0] r_s1_prod;
    logic [WIDTH-1:0]  r_s1_phase;
    logic              r_s1_last;

    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_s2_mag;
    logic [WIDTH-1:0]  r_s2_phase;
    logic              r_s2_last;

    logic [RND_W-1:0]  w_rnd;
    logic              w_sat;
    logic [WIDTH-1:0]  w_clip;

    ramp_state_t       r_state;
    ramp_state_t       w_state_nxt;
    logic [GAIN_W-1:0] r_cur_gain;
    logic [GAIN_W-1:0] r_target;
    logic [GAIN_W-1:0] w_cur_nxt;
    logic [GAIN_W-1:0] w_tgt_nxt;
    logic [GAIN_W-1:0] w_stepped;
    logic [GAIN_W-1:0] w_step;

    logic [WIDTH:0]    w_om_word;
    logic [WIDTH:0]    w_op_word;
    logic              w_om_valid;
    logic              w_op_valid;

    assign w_s2_adv    = ~r_s2_valid | w_f_ready;
    assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
    assign bus.i_tready = w_s1_adv & ce_rst_n;
    assign w_in_hs     = bus.i_tvalid & bus.i_tready;
    assign w_s2_load   = w_s2_adv & r_s1_valid;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_phase <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_in_hs;
            if (w_in_hs) begin
                r_s1_prod  <= PROD_W'(bus.i_tdata[2*WIDTH-1:WIDTH]) * PROD_W'(r_cur_gain);
                r_s1_phase <= bus.i_tdata[WIDTH-1:0];
                r_s1_last  <= bus.i_tlast;
            end
        end
    end

    // The extra sum bit keeps the rounding add from wrapping at full-scale products.
    assign w_rnd  = RND_W'(({1'b0, r_s1_prod} + RND_OFS) >> GAIN_FRAC);
    assign w_sat  = w_rnd > RND_W'(MAG_LIM);
    assign w_clip = w_sat ? MAG_LIM : w_rnd[WIDTH-1:0];

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_phase <= '0;
            r_s2_last  <= 1'b0;
        end else begin
            if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_s2_load) begin
                r_s2_mag   <= w_clip;
                r_s2_phase <= r_s1_phase;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    axis_fork2 #(
        .A_W (WIDTH + 1),
        .B_W (WIDTH + 1)
    ) u_fork (
        .clk       (ce_clk),
        .rst_n     (ce_rst_n),
        .i_valid   (r_s2_valid),
        .o_ready   (w_f_ready),
        .i_a_data  ({r_s2_last, r_s2_mag}),
        .i_b_data  ({r_s2_last, r_s2_phase}),
        .o_a_data  (w_om_word),
        .o_a_valid (w_om_valid),
        .i_a_ready (bus.om_tready),
        .o_b_data  (w_op_word),
        .o_b_valid (w_op_valid),
        .i_b_ready (bus.op_tready)
    );

    assign bus.om_tdata  = w_om_word[WIDTH-1:0];
    assign bus.om_tlast  = w_om_word[WIDTH];
    assign bus.om_tvalid = w_om_valid;
    assign bus.op_tdata  = w_op_word[WIDTH-1:0];
    assign bus.op_tlast  = w_op_word[WIDTH];
    assign bus.op_tvalid = w_op_valid;

    assign w_step = GAIN_W'(ramp_step);

    // One ramp step toward the pre-edge target, landing exactly on it rather than overshooting.
    always_comb begin
        w_stepped = r_target;
        if (r_cur_gain < r_target) begin
            if ((r_target - r_cur_gain) > w_step) w_stepped = r_cur_gain + w_step;
        end else if (r_cur_gain > r_target) begin
            if ((r_cur_gain - r_target) > w_step) w_stepped = r_cur_gain - w_step;
        end
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_state    <= HOLD;
            r_cur_gain <= GAIN_RST;
            r_target   <= GAIN_RST;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_gain <= w_cur_nxt;
            r_target   <= w_tgt_nxt;
        end
    end

    always_comb begin
        w_tgt_nxt = set_gain_stb ? set_gain : r_target;
        w_cur_nxt = r_cur_gain;
        if (ramp_step == '0) begin
            w_cur_nxt = w_tgt_nxt;
        end else if ((r_state == RAMP) && w_in_hs) begin
            w_cur_nxt = w_stepped;
        end
        w_state_nxt = (w_cur_nxt == w_tgt_nxt) ? HOLD : RAMP;
    end

    always_comb begin
        ramping = (r_state == RAMP);
    end

`ifdef MAGPHASE_GAIN_SAT_CNT_EN
    logic [15:0] r_sat_count;

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            r_sat_count <= '0;
        end else if (sat_clear) begin
            r_sat_count <= '0;
        end else if (w_s2_load && w_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count = r_sat_count;
`else
    logic w_unused_sat_clear;

    assign w_unused_sat_clear = sat_clear;
    assign sat_count          = '0;
`endif

endmodule
